serial_frame_deserializer: RTL and testbench

Downstream consumer of the serial shift-register chain: takes its 1-bit output stream, hunts for a sync pattern, then assembles a fixed number of MSB-first payload words per frame. Each completed word is presented on a single-entry valid/ready output register. Loss of back-pressure is flagged rather than stalling the serial side, since the chain cannot be paused.

---
 rtl/serial_frame_deserializer.sv | 132 +++++++++++++
 tb/tb_serial_frame_deserializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: hunts for a sync pattern in a 1-bit stream, then
// assembles FRAME_WORDS MSB-first words per frame into a valid/ready register.
module serial_frame_deserializer #(
   parameter int                  WIDTH        = 32,
   parameter int                  SYNC_LEN     = 8,
   parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 8'hA5,
   parameter int                  FRAME_WORDS  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             data_i,
   input  logic             bit_en_i,
   input  logic             resync_i,
   output logic [WIDTH-1:0] word_o,
   output logic             word_valid_o,
   input  logic             word_ready_i,
   output logic             locked_o,
   output logic             overflow_o
);

   localparam int BCW = $clog2(WIDTH);
   localparam int FCW = $clog2(SYNC_LEN + 1);
   localparam int WCW = $clog2(FRAME_WORDS + 1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
   localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);
   localparam logic [FCW-1:0] FILL_MAX  = FCW'(SYNC_LEN);
   localparam logic [FCW-1:0] FILL_ARM  = FCW'(SYNC_LEN - 1);

   typedef enum logic {HUNT, PAYLOAD} state_t;

   state_t state_q, state_d;
   // The oldest hunt bit and the oldest assembly bit are never read back:
   // the incoming bit completes both shift windows, so they are kept one short.
   logic [SYNC_LEN-2:0] hunt_q, hunt_d;
   logic [WIDTH-2:0]    asm_q, asm_d;
   logic [FCW-1:0]      fill_q, fill_d;
   logic [BCW-1:0]      bit_q, bit_d;
   logic [WCW-1:0]      wcnt_q, wcnt_d;
   logic [SYNC_LEN-1:0] hunt_shift;
   logic [WIDTH-1:0]    asm_shift;
   logic                complete;

   assign hunt_shift = {hunt_q, data_i};
   assign asm_shift  = {asm_q, data_i};
   assign locked_o   = (state_q == PAYLOAD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= HUNT;
         hunt_q  <= '0;
         asm_q   <= '0;
         fill_q  <= '0;
         bit_q   <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         hunt_q  <= hunt_d;
         asm_q   <= asm_d;
         fill_q  <= fill_d;
         bit_q   <= bit_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      hunt_d   = hunt_q;
      asm_d    = asm_q;
      fill_d   = fill_q;
      bit_d    = bit_q;
      wcnt_d   = wcnt_q;
      complete = 1'b0;
      if (resync_i) begin
         state_d = HUNT;
         hunt_d  = '0;
         asm_d   = '0;
         fill_d  = '0;
         bit_d   = '0;
         wcnt_d  = '0;
      end else if (bit_en_i) begin
         case (state_q)
            HUNT: begin
               hunt_d = hunt_shift[SYNC_LEN-2:0];
               if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
               if (fill_q >= FILL_ARM && hunt_shift == SYNC_PATTERN) begin
                  state_d = PAYLOAD;
                  bit_d   = '0;
                  wcnt_d  = '0;
               end
            end
            PAYLOAD: begin
               asm_d = asm_shift[WIDTH-2:0];
               if (bit_q == BIT_LAST) begin
                  complete = 1'b1;
                  bit_d    = '0;
                  if (wcnt_q == WORD_LAST) begin
                     // Frame end: hunt restarts from an empty window.
                     state_d = HUNT;
                     wcnt_d  = '0;
                     hunt_d  = '0;
                     fill_d  = '0;
                  end else begin
                     wcnt_d = wcnt_q + 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // Serial side cannot stall: a word arriving while the register is full is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_o       <= '0;
         word_valid_o <= 1'b0;
         overflow_o   <= 1'b0;
      end else if (complete) begin
         if (!word_valid_o || word_ready_i) begin
            word_o       <= asm_shift;
            word_valid_o <= 1'b1;
         end else begin
            overflow_o <= 1'b1;
         end
      end else if (word_valid_o && word_ready_i) begin
         word_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Bench for serial_frame_deserializer: directed and random streams checked
// every cycle against a bit-queue reference model.
module tb_serial_frame_deserializer;

   localparam int W  = 8;
   localparam int SL = 8;
   localparam int FW = 2;
   localparam logic [7:0] PAT = 8'hA5;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         data_i = 1'b0;
   logic         bit_en_i = 1'b0;
   logic         resync_i = 1'b0;
   logic         word_ready_i = 1'b0;
   logic [W-1:0] word_o;
   logic         word_valid_o;
   logic         locked_o;
   logic         overflow_o;

   int n_cmp = 0;
   int n_mis = 0;

   // reference model state
   bit         m_locked;
   int         hist[$];
   int         pay[$];
   int         m_wc;
   logic [7:0] m_word;
   bit         m_valid;
   bit         m_ovf;

   serial_frame_deserializer #(
      .WIDTH(W), .SYNC_LEN(SL), .SYNC_PATTERN(PAT), .FRAME_WORDS(FW)
   ) dut (
      .clk(clk), .reset(reset), .data_i(data_i), .bit_en_i(bit_en_i),
      .resync_i(resync_i), .word_o(word_o), .word_valid_o(word_valid_o),
      .word_ready_i(word_ready_i), .locked_o(locked_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_mis++;
         $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_all();
      chk("word_o", 32'(word_o), 32'(m_word));
      chk("word_valid_o", 32'(word_valid_o), 32'(m_valid));
      chk("locked_o", 32'(locked_o), 32'(m_locked));
      chk("overflow_o", 32'(overflow_o), 32'(m_ovf));
   endtask

   task automatic model_reset();
      m_locked = 0; hist.delete(); pay.delete(); m_wc = 0;
      m_word = '0; m_valid = 0; m_ovf = 0;
   endtask

   // One clock of behaviour: the window of the last SL bits since hunt entry
   // either equals the pattern or not; payload bits gather until W are held.
   task automatic model_step(input bit d, input bit en, input bit rs, input bit rdy);
      bit handshake = m_valid && rdy;
      bit complete = 0;
      int v;
      logic [7:0] w = '0;
      if (rs) begin
         m_locked = 0; hist.delete(); pay.delete(); m_wc = 0;
      end else if (en) begin
         if (!m_locked) begin
            hist.push_back(int'(d));
            if (hist.size() > SL) void'(hist.pop_front());
            if (hist.size() == SL) begin
               v = 0;
               foreach (hist[k]) v = v * 2 + hist[k];
               if (v == int'(PAT)) begin
                  m_locked = 1; pay.delete(); m_wc = 0;
               end
            end
         end else begin
            pay.push_back(int'(d));
            if (pay.size() == W) begin
               v = 0;
               foreach (pay[k]) v = v * 2 + pay[k];
               w = 8'(v);
               complete = 1;
               pay.delete();
               m_wc++;
               if (m_wc == FW) begin
                  m_locked = 0; m_wc = 0; hist.delete();
               end
            end
         end
      end
      if (complete) begin
         if (!m_valid || rdy) begin m_word = w; m_valid = 1; end
         else m_ovf = 1;
      end else if (handshake) m_valid = 0;
   endtask

   task automatic tx(input bit d, input bit en, input bit rs, input bit rdy);
      data_i = d; bit_en_i = en; resync_i = rs; word_ready_i = rdy;
      model_step(d, en, rs, rdy);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit toggle, input bit rdy);
      for (int i = 7; i >= 0; i--) begin
         tx(b[i], 1'b1, 1'b0, rdy);
         if (toggle) tx(1'($urandom_range(1)), 1'b0, 1'b0, rdy);
      end
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) tx(1'($urandom_range(1)), 1'b0, 1'b0, rdy);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      model_reset();
      #1;
      check_all();
      #3;
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      bit en, rdy, rs;
      int i;
      model_reset();
      #2;
      check_all();
      #10;
      reset = 1'b0;

      // basic frame
      send_byte(8'hA5, 0, 1); send_byte(8'h3C, 0, 1); send_byte(8'hC3, 0, 1);
      idle(3, 1);

      // noise before sync, then a sync byte carried as payload
      tx(1, 1, 0, 1); tx(0, 1, 0, 1); tx(1, 1, 0, 1); tx(0, 1, 0, 1);
      send_byte(8'hA5, 0, 1); send_byte(8'hFF, 0, 1); send_byte(8'h00, 0, 1);
      send_byte(8'hA5, 0, 1); send_byte(8'hA5, 0, 1); send_byte(8'h5A, 0, 1);
      idle(2, 1);

      // gated bit enable
      send_byte(8'hA5, 1, 1); send_byte(8'h3C, 1, 1); send_byte(8'hC3, 1, 1);
      idle(2, 1);

      // back-pressure: second word dropped, overflow sticky
      send_byte(8'hA5, 0, 0); send_byte(8'h3C, 0, 0); send_byte(8'hC3, 0, 0);
      idle(2, 0);
      idle(2, 1);
      send_byte(8'hA5, 0, 1); send_byte(8'h11, 0, 1); send_byte(8'h22, 0, 1);
      pulse_reset();

      // resync mid-word
      send_byte(8'hA5, 0, 1);
      tx(0, 1, 0, 1); tx(0, 1, 0, 1); tx(0, 1, 0, 1); tx(1, 1, 0, 1);
      tx(1, 1, 1, 1);
      idle(3, 1);
      send_byte(8'hA5, 0, 1); send_byte(8'h11, 0, 1); send_byte(8'h22, 0, 1);
      idle(1, 1);

      // async reset mid-word while holding a valid word
      send_byte(8'hA5, 0, 0); send_byte(8'h3C, 0, 0);
      tx(1, 1, 0, 0); tx(1, 1, 0, 0); tx(0, 1, 0, 0);
      pulse_reset();
      send_byte(8'hA5, 0, 1); send_byte(8'h11, 0, 1); send_byte(8'h22, 0, 1);
      idle(2, 1);

      // random streams, sync bytes injected often enough to lock repeatedly
      for (int c = 0; c < 120; c++) begin
         b = ($urandom_range(2) == 0) ? PAT : 8'($urandom);
         i = 7;
         while (i >= 0) begin
            en  = ($urandom_range(3) != 0);
            rdy = ($urandom_range(9) < 7);
            rs  = ($urandom_range(79) == 0);
            tx(en ? b[i] : 1'($urandom_range(1)), en, rs, rdy);
            if (en) i--;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
